// File: rtl/fft_pkg.sv
// Shared constants, complex sample type, twiddle ROM and bit-reverse helper
// for the 16-point iterative radix-2 DIT FFT.
package fft_pkg;

  localparam int N    = 16;
  localparam int LOGN = 4;
  localparam int DW   = 16;
  localparam int TW   = 16;
  localparam int FRAC = 14;
  localparam int CW   = 2 * DW;
  localparam int FW   = N * CW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Real part in the upper half, matching the frame packing.
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  function automatic logic signed [TW-1:0] tw_cos(input logic [2:0] m);
    case (m)
      3'd0:    return 16'sd16384;
      3'd1:    return 16'sd15137;
      3'd2:    return 16'sd11585;
      3'd3:    return 16'sd6270;
      3'd4:    return 16'sd0;
      3'd5:    return -16'sd6270;
      3'd6:    return -16'sd11585;
      default: return -16'sd15137;
    endcase
  endfunction

  function automatic logic signed [TW-1:0] tw_sin(input logic [2:0] m);
    case (m)
      3'd0:    return 16'sd0;
      3'd1:    return 16'sd6270;
      3'd2:    return 16'sd11585;
      3'd3:    return 16'sd15137;
      3'd4:    return 16'sd16384;
      3'd5:    return 16'sd15137;
      3'd6:    return 16'sd11585;
      default: return 16'sd6270;
    endcase
  endfunction

  function automatic logic [LOGN-1:0] rev4(input logic [LOGN-1:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 butterfly: t = W*b, a' = sat((a+t)>>>1), b' = sat((a-t)>>>1).
// W = c - j*s in Q1.14.
module fft_butterfly
  import fft_pkg::*;
(
  input  cplx_t                i_a,
  input  cplx_t                i_b,
  input  logic signed [TW-1:0] i_wc,
  input  logic signed [TW-1:0] i_ws,
  output cplx_t                o_a,
  output cplx_t                o_b
);

  localparam int PW = DW + TW;
  localparam int TF = PW + 1 - FRAC;
  localparam logic signed [TF-1:0] SAT_HI = TF'((1 <<< (DW - 1)) - 1);
  localparam logic signed [TF-1:0] SAT_LO = -SAT_HI - TF'(1);

  function automatic logic signed [DW-1:0] sat(input logic signed [TF-1:0] v);
    if (v > SAT_HI) return SAT_HI[DW-1:0];
    if (v < SAT_LO) return SAT_LO[DW-1:0];
    return v[DW-1:0];
  endfunction

  logic signed [DW-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [PW-1:0] w_cr, w_ci, w_sr, w_si;
  logic signed [PW:0]   w_tr_f, w_ti_f;
  logic signed [TF-1:0] w_tr, w_ti;
  logic signed [TF:0]   w_ra_p, w_ra_m, w_ia_p, w_ia_m;

  assign w_ar = $signed(i_a.re);
  assign w_ai = $signed(i_a.im);
  assign w_br = $signed(i_b.re);
  assign w_bi = $signed(i_b.im);

  assign w_cr = PW'(i_wc) * PW'(w_br);
  assign w_ci = PW'(i_wc) * PW'(w_bi);
  assign w_sr = PW'(i_ws) * PW'(w_br);
  assign w_si = PW'(i_ws) * PW'(w_bi);

  // Full-precision sums, then truncating arithmetic shift by the twiddle fraction.
  assign w_tr_f = (PW+1)'(w_cr) + (PW+1)'(w_si);
  assign w_ti_f = (PW+1)'(w_ci) - (PW+1)'(w_sr);
  assign w_tr   = w_tr_f[PW:FRAC];
  assign w_ti   = w_ti_f[PW:FRAC];

  assign w_ra_p = (TF+1)'(w_ar) + (TF+1)'(w_tr);
  assign w_ra_m = (TF+1)'(w_ar) - (TF+1)'(w_tr);
  assign w_ia_p = (TF+1)'(w_ai) + (TF+1)'(w_ti);
  assign w_ia_m = (TF+1)'(w_ai) - (TF+1)'(w_ti);

  assign o_a.re = sat(w_ra_p[TF:1]);
  assign o_a.im = sat(w_ia_p[TF:1]);
  assign o_b.re = sat(w_ra_m[TF:1]);
  assign o_b.im = sat(w_ia_m[TF:1]);

endmodule

// File: rtl/fft_top.sv
// 16-point iterative radix-2 DIT FFT: bit-reversed load, one full stage of
// eight butterflies per clock, registered scaled spectrum and endop pulse.
module fft_top
  import fft_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          Start,
  input  logic [FW-1:0] Data_In,
  output logic [FW-1:0] Data_Out,
  output logic          endop
);

  logic [1:0]      r_state;
  logic [1:0]      r_stage;
  cplx_t           r_x [N];
  logic [FW-1:0]   r_dout;
  logic            r_endop;

  cplx_t           w_next [N];
  cplx_t           w_ya   [N/2];
  cplx_t           w_yb   [N/2];
  logic [LOGN-1:0] w_ai   [N/2];
  logic [LOGN-1:0] w_bi   [N/2];
  logic [2:0]      w_m    [N/2];
  logic [FW-1:0]   w_pack;

  // Pair p of stage s: group p>>s, offset p mod 2^s, partner 2^s away.
  for (genvar p = 0; p < N/2; p++) begin : g_bf
    assign w_ai[p] = LOGN'(((p >> r_stage) << (32'(r_stage) + 1)) | (p & ((1 << r_stage) - 1)));
    assign w_bi[p] = w_ai[p] | LOGN'(1 << r_stage);
    assign w_m[p]  = 3'((p & ((1 << r_stage) - 1)) << (3 - 32'(r_stage)));

    fft_butterfly u_bf (
      .i_a  (r_x[w_ai[p]]),
      .i_b  (r_x[w_bi[p]]),
      .i_wc (tw_cos(w_m[p])),
      .i_ws (tw_sin(w_m[p])),
      .o_a  (w_ya[p]),
      .o_b  (w_yb[p])
    );
  end

  always_comb begin
    w_next = r_x;
    for (int p = 0; p < N/2; p++) begin
      w_next[w_ai[p]] = w_ya[p];
      w_next[w_bi[p]] = w_yb[p];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign w_pack[CW*k +: CW] = w_next[k];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_stage <= 2'd0;
      r_dout  <= '0;
      r_endop <= 1'b0;
      for (int n = 0; n < N; n++) r_x[n] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_endop <= 1'b0;
          if (Start) begin
            for (int n = 0; n < N; n++) r_x[rev4(LOGN'(n))] <= cplx_t'(Data_In[CW*n +: CW]);
            r_stage <= 2'd0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_x     <= w_next;
          r_stage <= r_stage + 2'd1;
          if (r_stage == 2'd3) begin
            r_dout  <= w_pack;
            r_endop <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_endop <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_endop <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Data_Out = r_dout;
  assign endop    = r_endop;

endmodule

// File: tb/tb_fft_top.sv
// Directed bench for fft_top: real-valued DFT/16 model feeds a scoreboard
// that is drained whenever endop pulses.
module tb_fft_top;

  logic         clock = 1'b0;
  logic         reset;
  logic         Start;
  logic [511:0] Data_In;
  logic [511:0] Data_Out;
  logic         endop;

  fft_top dut (
    .clock    (clock),
    .reset    (reset),
    .Start    (Start),
    .Data_In  (Data_In),
    .Data_Out (Data_Out),
    .endop    (endop)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [511:0] v;
    int           tol;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [15:0] rnd_sat(input real r);
    real f;
    f = $floor(r + 0.5);
    if (f > 32767.0)  f = 32767.0;
    if (f < -32768.0) f = -32768.0;
    return 16'($rtoi(f));
  endfunction

  function automatic logic [511:0] dft_model(input logic [511:0] x);
    logic [511:0]      y;
    logic signed [15:0] t;
    real xr[16], xi[16];
    real sr, si, th;
    for (int n = 0; n < 16; n++) begin
      t = x[32*n+16 +: 16]; xr[n] = t;
      t = x[32*n    +: 16]; xi[n] = t;
    end
    for (int k = 0; k < 16; k++) begin
      sr = 0.0; si = 0.0;
      for (int n = 0; n < 16; n++) begin
        th = 2.0 * 3.141592653589793 * real'(n * k) / 16.0;
        sr = sr + xr[n] * $cos(th) + xi[n] * $sin(th);
        si = si + xi[n] * $cos(th) - xr[n] * $sin(th);
      end
      y[32*k+16 +: 16] = rnd_sat(sr / 16.0);
      y[32*k    +: 16] = rnd_sat(si / 16.0);
    end
    return y;
  endfunction

  task automatic chk_i(input int obs, input int expv, input string tag);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_v(input logic [511:0] obs, input logic [511:0] expv, input string tag);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, expv);
    end
  endtask

  task automatic check_bins(input logic [511:0] obs, input exp_t e, input string tag);
    logic signed [15:0] o_r, o_i, e_r, e_i;
    int dr, di;
    for (int k = 0; k < 16; k++) begin
      o_r = obs[32*k+16 +: 16]; o_i = obs[32*k +: 16];
      e_r = e.v[32*k+16 +: 16]; e_i = e.v[32*k +: 16];
      dr = int'(o_r) - int'(e_r); if (dr < 0) dr = -dr;
      di = int'(o_i) - int'(e_i); if (di < 0) di = -di;
      n_tests++;
      assert (!$isunknown(obs[32*k +: 32]) && dr <= e.tol && di <= e.tol) else begin
        n_fail++;
        $error("FAIL %s X[%0d]: got %h, want %h (+/-%0d)", tag, k, obs[32*k +: 32], e.v[32*k +: 32], e.tol);
      end
    end
  endtask

  task automatic run_frame(input logic [511:0] din, input int tol, input string tag);
    exp_t e;
    int   c;
    @(negedge clock);
    Data_In = din; Start = 1'b1;
    e.v = dft_model(din); e.tol = tol;
    sb.push_back(e);
    @(negedge clock);
    Start = 1'b0; Data_In = ~din;
    c = 1;
    while (!endop && c < 20) begin
      @(negedge clock);
      c++;
    end
    chk_i(c, 5, {tag, " latency"});
    if (endop) begin
      e = sb.pop_front();
      check_bins(Data_Out, e, tag);
    end else begin
      void'(sb.pop_front());
    end
    @(negedge clock);
    chk_i(int'(endop), 0, {tag, " endop width"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] f_imp, f_dc, f_nyq, f_fs, f_tw, f_rnd, first;
    exp_t         e;
    int           cnt;
    bit           have_first;

    f_imp = '0; f_imp[31:0] = 32'h0010_0000;
    f_tw  = '0; f_tw[63:32] = 32'h4000_0000; f_tw[191:160] = 32'h0000_2000;
    for (int n = 0; n < 16; n++) begin
      f_dc[32*n +: 32]  = 32'h0010_0000;
      f_nyq[32*n +: 32] = (n % 2 == 0) ? 32'h0010_0000 : 32'hFFF0_0000;
      f_fs[32*n +: 32]  = 32'h7FFF_7FFF;
      f_rnd[32*n+16 +: 16] = 16'($urandom_range(0, 4095)) - 16'd2048;
      f_rnd[32*n    +: 16] = 16'($urandom_range(0, 4095)) - 16'd2048;
    end

    reset = 1'b0; Start = 1'b0; Data_In = '0;
    @(negedge clock); @(negedge clock);
    chk_v(Data_Out, '0, "reset Data_Out");
    chk_i(int'(endop), 0, "reset endop");
    reset = 1'b1;

    run_frame(f_imp, 0, "impulse");
    run_frame(f_dc,  1, "dc");
    run_frame(f_nyq, 1, "nyquist");
    run_frame(f_fs,  1, "fullscale");
    run_frame(f_tw,  3, "twiddle");
    run_frame(f_rnd, 3, "random");

    // Abort a frame mid-computation with an asynchronous reset.
    @(negedge clock);
    Data_In = f_dc; Start = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #2;
    chk_v(Data_Out, '0, "midcalc reset Data_Out");
    chk_i(int'(endop), 0, "midcalc reset endop");
    @(negedge clock);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (endop) cnt++;
    end
    chk_i(cnt, 0, "no endop after reset");

    // Start held high, dropped only during CALC: one frame every 6 clocks.
    have_first = 1'b0;
    @(negedge clock);
    Data_In = f_tw; Start = 1'b1;
    e.v = dft_model(f_tw); e.tol = 3;
    sb.push_back(e);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clock);
      chk_i(int'(endop), int'(c % 6 == 5), $sformatf("stream endop c=%0d", c));
      if (endop) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_bins(Data_Out, e, $sformatf("stream c=%0d", c));
        end
        if (have_first) chk_v(Data_Out, first, $sformatf("stream repeat c=%0d", c));
        else begin
          first = Data_Out;
          have_first = 1'b1;
        end
      end
      if (c == 36) Start = 1'b0;
      else Start = !((c % 6 == 2) || (c % 6 == 3));
      if ((c % 6 == 0) && (c < 36)) sb.push_back(e);
    end
    chk_i(sb.size(), 0, "scoreboard drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
